muldiv_unit: RTL and testbench

Iterative, multi-cycle multiply/divide engine that services the ALU's MUL and DIV operations and returns Hi, Lo and remain through a start/done handshake. It receives the same operand and opcode bus that the ALU receives (rda, rdx, alu_decode). It is the responder side of that bus: it computes one product or quotient per accepted request over 32 iterations. The control path stalls on busy and consumes the results on done.

---
 rtl/alu_pkg.sv | 16 +
 rtl/div_step.sv | 21 ++
 rtl/muldiv_unit.sv | 132 +++++++++++++
 tb/tb_muldiv_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, widths and state encoding shared by the ALU and its multiply/divide engine
package alu_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0110;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration producing the next partial remainder and quotient bit
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] t;

  // shift in the next dividend bit and subtract the divisor only when it fits
  always_comb begin
    t     = {rem_i, bit_i};
    q_o   = t >= {1'b0, div_i};
    rem_o = q_o ? WIDTH'(t - {1'b0, div_i}) : t[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned shift-add multiplier and restoring divider with start/done handshake
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_decode,
  input  logic [WIDTH-1:0] rda,
  input  logic [WIDTH-1:0] rdx,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] remain,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, rem_q, rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] mul_acc, div_acc;
  logic [WIDTH-1:0] ds_rem;
  logic             ds_q;
  logic             last;
  logic             is_mul, is_div;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i(acc_q[2*WIDTH-1:WIDTH]),
    .bit_i(acc_q[WIDTH-1]),
    .div_i(b_q),
    .rem_o(ds_rem),
    .q_o  (ds_q)
  );

  // state, operands, accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // next-state logic: acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    is_mul  = alu_decode == OP_MUL;
    is_div  = alu_decode == OP_DIV;
    last    = cnt_q == CW'(WIDTH - 1);
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_acc = {mul_sum, acc_q[WIDTH-1:1]};
    div_acc = {ds_rem, acc_q[WIDTH-2:0], ds_q};
    case (state_q)
      IDLE: begin
        if (start && (is_mul || is_div)) begin
          state_d = is_mul ? MUL : DIV;
          cnt_d   = '0;
          dz_d    = 1'b0;
          b_d     = is_mul ? rda : rdx;
          acc_d   = {{WIDTH{1'b0}}, is_mul ? rdx : rda};
        end
      end
      MUL: begin
        acc_d = mul_acc;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          hi_d    = mul_acc[2*WIDTH-1:WIDTH];
          lo_d    = mul_acc[WIDTH-1:0];
          rem_d   = '0;
        end
      end
      DIV: begin
        if (b_q == '0) begin
          state_d = DONE;
          hi_d    = '0;
          lo_d    = '1;
          rem_d   = acc_q[WIDTH-1:0];
          dz_d    = 1'b1;
        end else begin
          acc_d = div_acc;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = DONE;
            hi_d    = '0;
            lo_d    = div_acc[WIDTH-1:0];
            rem_d   = div_acc[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign remain   = rem_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench with directed multiply/divide vectors
module tb_muldiv_unit;

  localparam logic [3:0] MULOP = 4'b0101;
  localparam logic [3:0] DIVOP = 4'b0110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_decode = '0;
  logic [31:0] rda = '0, rdx = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo, remain;

  typedef struct {
    logic [31:0] hi, lo, rem;
    logic        dz;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .alu_decode(alu_decode),
    .rda(rda), .rdx(rdx), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .remain(remain), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("remain", remain, e.rem);
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("latency", 32'(cyc - e.cyc), 32'(e.lat));
      end
    end else if (!rst && q.size() != 0) chk("busy_in_flight", 32'(busy), 32'd1);
  end

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic [31:0] er,
                        input logic edz, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1; alu_decode = op; rda = a; rdx = b;
    @(posedge clk);
    #1;
    start = 1'b0; rda = '1; rdx = '1; alu_decode = '0;
    e.hi = eh; e.lo = el; e.rem = er; e.dz = edz; e.lat = lat; e.cyc = cyc;
    if (push) q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_remain", remain, 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);

    launch(MULOP, 32'd5, 32'd3, 32'd0, 32'd15, 32'd0, 1'b0, 32, 1'b1);
    wait_done();
    launch(MULOP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'd0, 1'b0, 32, 1'b1);
    wait_done();
    launch(DIVOP, 32'd10, 32'd2, 32'd0, 32'd5, 32'd0, 1'b0, 32, 1'b1);
    wait_done();
    launch(DIVOP, 32'd100, 32'd7, 32'd0, 32'd14, 32'd2, 1'b0, 32, 1'b1);
    wait_done();
    launch(DIVOP, 32'd3, 32'd9, 32'd0, 32'd0, 32'd3, 1'b0, 32, 1'b1);
    wait_done();
    launch(DIVOP, 32'd9, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b1, 1, 1'b1);
    wait_done();
    launch(MULOP, 32'd2, 32'd3, 32'd0, 32'd6, 32'd0, 1'b0, 32, 1'b1);
    @(negedge clk);
    chk("dz_cleared", 32'(div_zero), 32'd0);
    wait_done();

    @(negedge clk);
    start = 1'b1; alu_decode = 4'b0001; rda = 32'd8; rdx = 32'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("badop_busy", 32'(busy), 32'd0);
    chk("badop_lo", lo, 32'd6);
    chk("badop_hi", hi, 32'd0);

    launch(MULOP, 32'd1234, 32'd1000, 32'd0, 32'd1234000, 32'd0, 1'b0, 32, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; alu_decode = MULOP; rda = 32'd7; rdx = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    launch(DIVOP, 32'd1000, 32'd3, 32'd0, 32'd0, 32'd0, 1'b0, 32, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_remain", remain, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_done_busy", 32'(busy), 32'd0);

    launch(MULOP, 32'd6, 32'd7, 32'd0, 32'd42, 32'd0, 1'b0, 32, 1'b1);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
